// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder sequencer: feeds one nibble per cycle (LSB first) to an external
// 4-bit adder and assembles the NIBBLES*4-bit sum plus carry-out behind valid/ready.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout,
    output logic                 busy,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_sum;
    logic              r_carry;
    logic [IDXW-1:0]   r_idx;
    logic [IDXW+1:0]   w_base;
    logic              w_last;

    assign w_base = {r_idx, 2'b00};
    assign w_last = (r_idx == IDXW'(NIBBLES - 1));

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: w_next gets a default first so no path through the case leaves it unassigned.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_RUN) || (r_state == S_DONE);
        add_a     = 4'h0;
        add_b     = 4'h0;
        add_cin   = 1'b0;
        if (r_state == S_RUN) begin
            add_a   = r_a[w_base +: 4];
            add_b   = r_b[w_base +: 4];
            add_cin = r_carry;
        end
    end

    // Index returns to 0 after the top nibble so it never points past NIBBLES-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_carry <= in_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: 4] <= add_sum;
                    r_carry            <= add_cout;
                    r_idx              <= w_last ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_carry;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl: NIBBLES=4 and NIBBLES=2 instances, each with a
// behavioural 4-bit adder, checked by a vector table, corner sequences and a scoreboard.
module tb_nibble_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid4, in_ready4, in_cin4, out_valid4, out_ready4, out_cout4, busy4;
    logic [15:0] in_a4, in_b4, out_sum4;
    logic [3:0]  add_a4, add_b4, add_sum4;
    logic        add_cin4, add_cout4;

    logic        in_valid2, in_ready2, in_cin2, out_valid2, out_ready2, out_cout2, busy2;
    logic [7:0]  in_a2, in_b2, out_sum2;
    logic [3:0]  add_a2, add_b2, add_sum2;
    logic        add_cin2, add_cout2;

    assign {add_cout4, add_sum4} = add_a4 + add_b4 + add_cin4;
    assign {add_cout2, add_sum2} = add_a2 + add_b2 + add_cin2;

    nibble_serial_add_ctrl #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_a(in_a4), .in_b(in_b4), .in_cin(in_cin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_sum(out_sum4), .out_cout(out_cout4), .busy(busy4),
        .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
        .add_sum(add_sum4), .add_cout(add_cout4)
    );

    nibble_serial_add_ctrl #(.NIBBLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_cin(in_cin2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_sum(out_sum2), .out_cout(out_cout2), .busy(busy2),
        .add_a(add_a2), .add_b(add_b2), .add_cin(add_cin2),
        .add_sum(add_sum2), .add_cout(add_cout2)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        int          bp;
    } vec_t;

    vec_t        vecs[7];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [16:0] q4[$];
    logic [8:0]  q2[$];
    logic [3:0]  tr_a[8];
    logic [3:0]  tr_b[8];
    logic        tr_cin[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got no event within the cycle budget, expected one", name);
    endtask

    // Scoreboard bookkeeping for the upcoming edge, then advance to 1 time unit after it.
    task automatic step();
        logic [16:0] e4;
        logic [8:0]  e2;
        if (rst_n) begin
            if (in_valid4 && in_ready4) begin
                e4 = {1'b0, in_a4} + {1'b0, in_b4} + {16'h0, in_cin4};
                q4.push_back(e4);
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) fail_now("sb4_underflow");
                else begin
                    e4 = q4.pop_front();
                    check("sb4_result", {15'h0, out_cout4, out_sum4}, {15'h0, e4});
                end
            end
            if (in_valid2 && in_ready2) begin
                e2 = {1'b0, in_a2} + {1'b0, in_b2} + {8'h0, in_cin2};
                q2.push_back(e2);
            end
            if (out_valid2 && out_ready2) begin
                if (q2.size() == 0) fail_now("sb2_underflow");
                else begin
                    e2 = q2.pop_front();
                    check("sb2_result", {23'h0, out_cout2, out_sum2}, {23'h0, e2});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_op4(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] esum, input logic ecout, input int bp,
                          input string tag);
        int n;
        in_a4 = a; in_b4 = b; in_cin4 = cin; in_valid4 = 1'b1; out_ready4 = 1'b0;
        check({tag, "_in_ready"}, in_ready4, 1);
        step();
        in_valid4 = 1'b0;
        n = 0;
        while (!out_valid4 && n < 20) begin
            if (n < 8) begin
                tr_a[n] = add_a4; tr_b[n] = add_b4; tr_cin[n] = add_cin4;
            end
            step();
            n++;
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_sum"}, out_sum4, esum);
        check({tag, "_cout"}, out_cout4, ecout);
        check({tag, "_busy_done"}, busy4, 1);
        check({tag, "_add_a_done"}, add_a4, 0);
        check({tag, "_add_cin_done"}, add_cin4, 0);
        for (int i = 0; i < bp; i++) begin
            in_valid4 = (i % 2 == 0);
            in_a4 = 16'($urandom); in_b4 = 16'($urandom); in_cin4 = 1'($urandom);
            step();
            check({tag, "_bp_valid"}, out_valid4, 1);
            check({tag, "_bp_sum"}, out_sum4, esum);
            check({tag, "_bp_cout"}, out_cout4, ecout);
            check({tag, "_bp_in_ready"}, in_ready4, 0);
        end
        in_valid4 = 1'b0; out_ready4 = 1'b1;
        step();
        out_ready4 = 1'b0;
        check({tag, "_ret_valid"}, out_valid4, 0);
        check({tag, "_ret_in_ready"}, in_ready4, 1);
        check({tag, "_ret_busy"}, busy4, 0);
    endtask

    task automatic rand4();
        int  acc_n = 0;
        int  cyc   = 0;
        int  last  = 0;
        int  n     = 0;
        bit  acc;
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        in_a4 = 16'($urandom); in_b4 = 16'($urandom); in_cin4 = 1'($urandom);
        while (acc_n < 100 && cyc < 3000) begin
            acc = in_valid4 && in_ready4;
            step();
            cyc++;
            if (acc) begin
                if (acc_n > 0) check("tput4", cyc - last, 6);
                last = cyc;
                acc_n++;
                in_a4 = 16'($urandom); in_b4 = 16'($urandom); in_cin4 = 1'($urandom);
                if (acc_n == 100) in_valid4 = 1'b0;
            end
        end
        in_valid4 = 1'b0;
        if (acc_n < 100) fail_now("rand4_accepts");
        while (q4.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (q4.size() != 0) fail_now("rand4_drain");
        out_ready4 = 1'b0;
    endtask

    task automatic rand2();
        int  acc_n = 0;
        int  cyc   = 0;
        int  last  = 0;
        int  n     = 0;
        bit  acc;
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        in_a2 = 8'($urandom); in_b2 = 8'($urandom); in_cin2 = 1'($urandom);
        while (acc_n < 100 && cyc < 3000) begin
            acc = in_valid2 && in_ready2;
            step();
            cyc++;
            if (acc) begin
                if (acc_n > 0) check("tput2", cyc - last, 4);
                last = cyc;
                acc_n++;
                in_a2 = 8'($urandom); in_b2 = 8'($urandom); in_cin2 = 1'($urandom);
                if (acc_n == 100) in_valid2 = 1'b0;
            end
        end
        in_valid2 = 1'b0;
        if (acc_n < 100) fail_now("rand2_accepts");
        while (q2.size() != 0 && n < 50) begin
            step();
            n++;
        end
        if (q2.size() != 0) fail_now("rand2_drain");
        out_ready2 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 5};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
        vecs[5] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 0};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, 0};

        in_valid4 = 0; in_a4 = 0; in_b4 = 0; in_cin4 = 0; out_ready4 = 0;
        in_valid2 = 0; in_a2 = 0; in_b2 = 0; in_cin2 = 0; out_ready2 = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready4, 0);
        check("rst_out_valid", out_valid4, 0);
        check("rst_busy", busy4, 0);
        check("rst_out_sum", out_sum4, 0);
        check("rst_out_cout", out_cout4, 0);
        check("rst_add_a", add_a4, 0);
        check("rst_add_b", add_b4, 0);
        check("rst_add_cin", add_cin4, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready4, 1);
        step();

        for (int i = 0; i < 7; i++) begin
            do_op4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout,
                   vecs[i].bp, $sformatf("vec%0d", i));
            if (i == 0) begin
                check("vec0_first_add_a", tr_a[0], 4'h4);
                check("vec0_first_add_b", tr_b[0], 4'hF);
                check("vec0_first_add_cin", tr_cin[0], 0);
            end
            if (i == 1) begin
                check("vec1_ripple_c0", tr_cin[0], 0);
                check("vec1_ripple_c1", tr_cin[1], 1);
                check("vec1_ripple_c2", tr_cin[2], 1);
                check("vec1_ripple_c3", tr_cin[3], 1);
            end
        end

        // Reset in the second RUN cycle: everything must clear without waiting for an edge.
        in_a4 = 16'h1234; in_b4 = 16'h1111; in_cin4 = 1'b0; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        step();
        check("mid_busy", busy4, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid4, 0);
        check("arst_in_ready", in_ready4, 0);
        check("arst_busy", busy4, 0);
        check("arst_add_a", add_a4, 0);
        check("arst_add_b", add_b4, 0);
        check("arst_add_cin", add_cin4, 0);
        check("arst_out_sum", out_sum4, 0);
        check("arst_out_cout", out_cout4, 0);
        q4.delete();
        step();
        step();
        check("in_rst_in_ready", in_ready4, 0);
        check("in_rst_out_valid", out_valid4, 0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", in_ready4, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rel_no_stray_valid", out_valid4, 0);
        end
        do_op4(16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 0, "rst_add");

        rand4();
        rand2();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that adds two NIBBLES*4-bit operands using one external 4-bit ripple adder, one nibble per cycle, LSB first.
- Sits directly upstream of the 4-bit adder: drives its a/b/cin inputs and consumes its sum/cout combinationally in the same cycle.
- Receives operands over a valid/ready handshake and returns the wide sum and carry-out over a second valid/ready handshake.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 2..16.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block can accept operands.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_cin  input  1  carry-in to nibble 0.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_sum  output  W  registered sum.
- out_cout  output  1  registered carry-out of top nibble.
- busy  output  1  high in RUN or DONE.
- add_a  output  4  nibble of A to the adder.
- add_b  output  4  nibble of B to the adder.
- add_cin  output  1  carry into the adder.
- add_sum  input  4  adder sum; combinational response to add_a/add_b/add_cin.
- add_cout  input  1  adder carry-out.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; a_reg, b_reg, sum_reg, carry_reg and idx clear to 0.
  - out_valid=0, out_sum=0, out_cout=0, busy=0, add_a=0, add_b=0, add_cin=0.
  - in_ready is forced 0 while rst_n is low.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at an edge: capture in_a, in_b into a_reg, b_reg; carry_reg<=in_cin; idx<=0; sum_reg<=0; go to RUN.
  - While in_valid is low, all registers hold.
- RUN:
  - Adder drive: add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin=carry_reg.
  - Each edge: sum_reg[4*idx+:4]<=add_sum; carry_reg<=add_cout; idx<=idx+1.
  - On the edge where idx==NIBBLES-1 the last nibble is captured and the state goes to DONE.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1, out_sum=sum_reg, out_cout=carry_reg; both held stable until handshake.
  - On out_valid&&out_ready at an edge: go to IDLE.
  - in_ready stays 0 in DONE, so accept and return never overlap.
- add_a, add_b and add_cin are 0 in IDLE and DONE.
- Latency and throughput:
  - If operands are accepted at edge E0, out_valid rises after edge E0+NIBBLES.
  - With out_ready held high, the next accept is possible at edge E0+NIBBLES+2, i.e. one operation per NIBBLES+2 cycles.
- Arithmetic: {out_cout,out_sum} = in_a + in_b + in_cin, computed modulo 2^(W+1) (no truncation of the carry). No signed overflow flag.
- idx width is clog2(NIBBLES); it never wraps past NIBBLES-1.
- Reset mid-RUN or mid-DONE: the partial result is discarded and no out_valid pulse follows. After rst_n rises, the block is in IDLE.
- Simultaneous events:
  - A new in_valid arriving in the same cycle as the DONE handshake is not accepted until the following IDLE cycle.
  - out_ready asserted outside DONE has no effect.

Test Plan:
- NIBBLES=4; in_a=0x1234, in_b=0x0FFF, in_cin=0 -> out_valid rises 4 cycles after accept; out_sum=0x2233, out_cout=0. In the first RUN cycle, add_a=0x4, add_b=0xF, add_cin=0.
- in_a=0xFFFF, in_b=0x0001, in_cin=0 -> out_sum=0x0000, out_cout=1; carry ripples through all 4 slices (add_cin=1 in RUN cycles 2-4).
- in_a=0xFFFF, in_b=0x0000, in_cin=1 -> out_sum=0x0000, out_cout=1; in_a=0, in_b=0, in_cin=0 -> out_sum=0, out_cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands -> out_sum and out_cout stay stable, in_ready=0, new operands not captured. Raising out_ready gives IDLE on the next edge.
- Reset: drop rst_n during the second RUN cycle -> all outputs are 0 immediately (asynchronously), in_ready=0 during reset, no stray out_valid. After release, in_ready=1 and a fresh add of 3+5 returns 0x0008.
- Back-to-back with out_ready=1 and in_valid=1: accepts occur every 6 cycles (NIBBLES+2). Use random operands over 100 ops, checked against a reference model; repeat with NIBBLES=2.
